// File: rtl/attn_pkg.sv
// Shared definitions for the attention-engine host-side blocks.
package attn_pkg;

    // Q1.6 feature width
    localparam int unsigned ATTN_DW = 8;
    // Features per query/key vector
    localparam int unsigned N_FEAT_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SEND = 2'b01,
        DONE = 2'b10
    } qk_tx_state_t;

endpackage

// File: rtl/qk_stream_tx_if.sv
// Valid/ready byte stream toward the engine's feature-input port.
interface qk_stream_tx_if
    import attn_pkg::*;
#(
    parameter int unsigned DATA_W = ATTN_DW
);

    logic [DATA_W-1:0] data;
    logic              vld;
    logic              rdy;
    logic              last;

    modport master (output data, output vld, output last, input rdy);
    modport slave  (input data, input vld, input last, output rdy);

endinterface

// File: rtl/qk_feature_buf.sv
// Query/key feature store: synchronous write, combinational read by beat.
module qk_feature_buf
    import attn_pkg::*;
#(
    parameter int unsigned N_FEAT = N_FEAT_DEFAULT,
    parameter int unsigned DATA_W = ATTN_DW,
    localparam int unsigned IDX_W = $clog2(N_FEAT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic              wr_sel,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              sel,
    input  logic [IDX_W-1:0]  idx,
    output logic [DATA_W-1:0] rd_data
);

    // [0] = query, [1] = key
    logic [DATA_W-1:0] mem_q [2][N_FEAT];

    // Register file update; reset clears every feature to zero
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < 2; s++) begin
                for (int i = 0; i < N_FEAT; i++) begin
                    mem_q[s][i] <= '0;
                end
            end
        end else if (wr_en) begin
            mem_q[wr_sel][wr_idx] <= wr_data;
        end
    end

    // Read port addressed by the beat index split into (idx, sel)
    always_comb begin
        rd_data = mem_q[sel][idx];
    end

endmodule

// File: rtl/qk_stream_tx.sv
// Streams interleaved q/k feature pairs to the attention engine input.
module qk_stream_tx
    import attn_pkg::*;
#(
    parameter int unsigned N_FEAT = N_FEAT_DEFAULT,
    parameter int unsigned DATA_W = ATTN_DW,
    localparam int unsigned IDX_W = $clog2(N_FEAT),
    localparam int unsigned BEAT_W = IDX_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic              wr_sel,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err,
    qk_stream_tx_if.master    m
);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(2 * N_FEAT - 1);

    qk_tx_state_t      state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              vld_q, vld_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              err_q, err_d;

    logic              buf_we;
    logic [BEAT_W-1:0] rd_beat;
    logic [DATA_W-1:0] rd_data;
    logic              fwd_q0;

    qk_feature_buf #(
        .N_FEAT (N_FEAT),
        .DATA_W (DATA_W)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (buf_we),
        .wr_sel  (wr_sel),
        .wr_idx  (wr_idx),
        .wr_data (wr_data),
        .sel     (rd_beat[0]),
        .idx     (rd_beat[BEAT_W-1:1]),
        .rd_data (rd_data)
    );

    // Read address: beat 0 when launching, otherwise the beat after the one on the bus
    always_comb begin
        rd_beat = '0;
        if (state_q == SEND) begin
            rd_beat = beat_q + 1'b1;
        end
    end

    // A q[0] write in the start cycle has not landed yet, so bypass it into beat 0
    always_comb begin
        fwd_q0 = wr_en && !wr_sel && (wr_idx == '0);
    end

    // Next-state, stream register and error-flag logic
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        vld_d   = vld_q;
        data_d  = data_q;
        err_d   = err_q;
        buf_we  = 1'b0;
        unique case (state_q)
            IDLE: begin
                buf_we = wr_en;
                if (start) begin
                    state_d = SEND;
                    beat_d  = '0;
                    vld_d   = 1'b1;
                    data_d  = fwd_q0 ? wr_data : rd_data;
                end
            end
            SEND: begin
                if (wr_en || start) begin
                    err_d = 1'b1;
                end
                if (vld_q && m.rdy) begin
                    if (beat_q == LAST_BEAT) begin
                        state_d = DONE;
                        vld_d   = 1'b0;
                    end else begin
                        beat_d = beat_q + 1'b1;
                        data_d = rd_data;
                    end
                end
            end
            DONE: begin
                buf_we  = wr_en;
                state_d = IDLE;
                if (start) begin
                    err_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                vld_d   = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            beat_q  <= '0;
            vld_q   <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            vld_q   <= vld_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    // Outputs decoded from registered state only
    always_comb begin
        m.data = data_q;
        m.vld  = vld_q;
        m.last = vld_q && (beat_q == LAST_BEAT);
        busy   = (state_q == SEND);
        done   = (state_q == DONE);
        err    = err_q;
    end

endmodule

// File: tb/tb_qk_stream_tx.sv
// Scoreboard bench for qk_stream_tx: stimulus pushes expected beats, a monitor pops them.
module tb_qk_stream_tx;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } beat_t;

    logic       clk;
    logic       rst_n;
    logic       wr_en;
    logic       wr_sel;
    logic [1:0] wr_idx;
    logic [7:0] wr_data;
    logic       start;
    logic       busy;
    logic       done;
    logic       err;

    qk_stream_tx_if #(.DATA_W(8)) m_if ();

    qk_stream_tx #(
        .N_FEAT (4),
        .DATA_W (8)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_sel  (wr_sel),
        .wr_idx  (wr_idx),
        .wr_data (wr_data),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .m       (m_if.master)
    );

    int    tests = 0;
    int    fails = 0;
    int    hs_count = 0;
    bit    rdy_rand = 1'b0;
    beat_t sb[$];

    logic [7:0] exp_orig [8];
    logic [7:0] exp_zero [8];
    logic [7:0] exp_q1   [8];
    logic [7:0] exp_q0q1 [8];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Random ready, changed away from both edges
    always @(posedge clk) begin
        #2;
        if (rdy_rand) m_if.rdy = 1'($urandom_range(0, 1));
    end

    // Monitor: compare the presented beat against the scoreboard head every cycle
    always @(negedge clk) begin
        if (rst_n) begin
            if (m_if.vld) begin
                if (sb.size() == 0) begin
                    check("unexpected_beat", 32'(m_if.data), 32'hFFFF_FFFF);
                end else begin
                    check("beat_data", 32'(m_if.data), 32'(sb[0].data));
                    check("beat_last", 32'(m_if.last), 32'(sb[0].last));
                    check("busy_in_stream", 32'(busy), 32'd1);
                    if (m_if.rdy) begin
                        void'(sb.pop_front());
                        hs_count++;
                    end
                end
            end else begin
                check("last_without_vld", 32'(m_if.last), 32'd0);
            end
        end
    end

    task automatic write(input logic sel, input logic [1:0] idx, input logic [7:0] data);
        wr_en = 1'b1; wr_sel = sel; wr_idx = idx; wr_data = data;
        tick();
        wr_en = 1'b0;
    endtask

    // Push expected beats then pulse start, optionally with a same-cycle write
    task automatic start_xfer(input logic [7:0] exp [8], input logic w, input logic wsel,
                              input logic [1:0] widx, input logic [7:0] wdata);
        beat_t b;
        for (int i = 0; i < 8; i++) begin
            b.data = exp[i];
            b.last = (i == 7);
            sb.push_back(b);
        end
        start = 1'b1;
        wr_en = w; wr_sel = wsel; wr_idx = widx; wr_data = wdata;
        tick();
        start = 1'b0;
        wr_en = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 200) begin
            tick();
            cyc++;
        end
        check("done_seen", 32'(done), 32'd1);
    endtask

    initial begin
        int cyc;
        int hs0;
        exp_orig = '{8'h40, 8'h40, 8'h20, 8'hE0, 8'hC0, 8'h40, 8'h7F, 8'h01};
        exp_zero = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        exp_q1   = '{8'h00, 8'h00, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        exp_q0q1 = '{8'h66, 8'h00, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

        rst_n = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; wr_idx = '0; wr_data = '0;
        start = 1'b0; m_if.rdy = 1'b1;
        tick();
        tick();
        check("rst_vld", 32'(m_if.vld), 32'd0);
        check("rst_data", 32'(m_if.data), 32'd0);
        check("rst_last", 32'(m_if.last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        tick();

        // Load Q and K
        write(1'b0, 2'd0, 8'h40); write(1'b0, 2'd1, 8'h20);
        write(1'b0, 2'd2, 8'hC0); write(1'b0, 2'd3, 8'h7F);
        write(1'b1, 2'd0, 8'h40); write(1'b1, 2'd1, 8'hE0);
        write(1'b1, 2'd2, 8'h40); write(1'b1, 2'd3, 8'h01);

        // Back-to-back stream with ready held high
        hs0 = hs_count;
        start_xfer(exp_orig, 1'b0, 1'b0, 2'd0, 8'h00);
        check("first_vld", 32'(m_if.vld), 32'd1);
        check("first_busy", 32'(busy), 32'd1);
        wait_done(cyc);
        check("done_latency", 32'(cyc + 1), 32'd9);
        check("done_vld_low", 32'(m_if.vld), 32'd0);
        check("done_busy_low", 32'(busy), 32'd0);
        check("hs_fast", 32'(hs_count - hs0), 32'd8);
        tick();
        check("done_pulse_1cyc", 32'(done), 32'd0);
        check("err_clean", 32'(err), 32'd0);

        // Random backpressure
        rdy_rand = 1'b1;
        hs0 = hs_count;
        start_xfer(exp_orig, 1'b0, 1'b0, 2'd0, 8'h00);
        wait_done(cyc);
        rdy_rand = 1'b0;
        m_if.rdy = 1'b1;
        check("hs_random", 32'(hs_count - hs0), 32'd8);
        check("err_clean_rand", 32'(err), 32'd0);
        tick();

        // start and write while busy: ignored, err set
        start_xfer(exp_orig, 1'b0, 1'b0, 2'd0, 8'h00);
        start = 1'b1; wr_en = 1'b1; wr_sel = 1'b0; wr_idx = 2'd0; wr_data = 8'h11;
        tick();
        start = 1'b0; wr_en = 1'b0;
        wait_done(cyc);
        check("err_busy", 32'(err), 32'd1);
        tick();
        start_xfer(exp_orig, 1'b0, 1'b0, 2'd0, 8'h00);
        wait_done(cyc);
        tick();

        // Reset after three handshakes
        hs0 = hs_count;
        start_xfer(exp_orig, 1'b0, 1'b0, 2'd0, 8'h00);
        tick(); tick(); tick();
        check("hs_before_rst", 32'(hs_count - hs0), 32'd3);
        rst_n = 1'b0;
        sb.delete();
        tick();
        check("abort_vld", 32'(m_if.vld), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        tick();
        start_xfer(exp_zero, 1'b0, 1'b0, 2'd0, 8'h00);
        wait_done(cyc);
        tick();

        // Same-cycle writes with start
        start_xfer(exp_q1, 1'b1, 1'b0, 2'd1, 8'h55);
        wait_done(cyc);
        tick();
        start_xfer(exp_q0q1, 1'b1, 1'b0, 2'd0, 8'h66);
        wait_done(cyc);
        tick();

        // start during DONE: ignored, err set
        start_xfer(exp_q0q1, 1'b0, 1'b0, 2'd0, 8'h00);
        wait_done(cyc);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("done_start_busy", 32'(busy), 32'd0);
        check("done_start_err", 32'(err), 32'd1);
        tick();
        tick();
        check("done_start_vld", 32'(m_if.vld), 32'd0);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/qk_stream_tx.md
# qk_stream_tx

Transmitter for the attention engine's 8-bit valid/ready feature-input port. It holds one query vector and one key vector of `N_FEAT` Q1.6 features, loaded through a simple register-write port. On `start` it streams them as interleaved pairs q0,k0,q1,k1,… to the engine's slave input (`ui_in` / `uio[0]` / `uio[1]`). It sits on the host/test-harness side of that interface and is the only producer the engine's input handshake needs.

## Interface
- `N_FEAT`, default 4: features per vector; sets beat count 2·N_FEAT.
- `DATA_W`, default 8: feature width; Q1.6 signed, two's complement.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `wr_en`  in  1  feature-buffer write strobe.
- `wr_sel`  in  1  0 = query buffer, 1 = key buffer.
- `wr_idx`  in  $clog2(N_FEAT)  feature index.
- `wr_data`  in  DATA_W  Q1.6 feature value.
- `start`  in  1  begin one transfer of all pairs.
- `busy`  out  1  high from the cycle after an accepted `start` until the final handshake.
- `done`  out  1  one-cycle pulse after the final handshake.
- `err`  out  1  sticky; set by `wr_en` or `start` while busy; cleared only by reset.
- `m_data`  out  DATA_W  stream data toward engine `ui_in`.
- `m_vld`  out  1  stream valid toward engine `uio_in[0]`.
- `m_rdy`  in  1  stream ready from engine `uio_out[1]`.
- `m_last`  out  1  high with the final beat (k[N_FEAT-1]).

## Operation
- FSM states: IDLE, SEND, DONE.
  - IDLE → SEND when `start`=1.
  - SEND → DONE on the handshake of the last beat.
  - DONE → IDLE unconditionally after one cycle.
- Feature buffer: 2×N_FEAT registers, reset to 0.
  - Writes are accepted only in IDLE and DONE.
  - A write to the same index in the same cycle as `start` lands before the transfer begins. The transfer sends the new value.
- Beat order: beat b = 2i sends q[i]; beat b = 2i+1 sends k[i], for i = 0..N_FEAT-1.
- Beat counter: width $clog2(2·N_FEAT).
  - Cleared on `start`.
  - Increments only on a handshake (`m_vld` & `m_rdy`).
  - No wrap inside a transfer; the last-beat handshake ends SEND.
- Stream rules:
  - `m_vld` and `m_data` are registered. `m_vld` never depends combinationally on `m_rdy`.
  - Once `m_vld`=1, it and `m_data` hold unchanged until a handshake occurs.
  - `m_last` = `m_vld` & (beat == 2·N_FEAT−1).
- `start` outside IDLE: ignored and sets `err`. A `start` in the DONE cycle is also ignored; `err` is set.
- `wr_en` in SEND: ignored and sets `err`.
- Data is passed through unmodified; no saturation or arithmetic.

## Timing
- Reset values: `m_vld`=0, `m_data`=0, `m_last`=0, `busy`=0, `done`=0, `err`=0. FSM in IDLE, counter 0.
- Reset during SEND aborts immediately. `m_vld` is low the next cycle and the buffer is cleared.
- `start` sampled at cycle t:
  - `m_vld`=1 with q0 and `busy`=1 at t+1.
  - With `m_rdy` held high, one beat per cycle; the last beat is presented at t+2·N_FEAT.
- Last handshake at cycle h: `done`=1 and `busy`=0 at h+1 (DONE state). `m_vld`=0 at h+1.
- Minimum start-to-start period: 2·N_FEAT+2 cycles.
- Stalls: `m_rdy` low for k cycles delays every subsequent beat by k cycles. No beat is lost or duplicated.
- Engine compatibility: the engine accepts beat 0 on `rdy`, then waits for a second valid beat. Beat 1 (k0) must therefore follow beat 0 with `m_vld` held high; this block guarantees that.

## Structure
- Shared package `attn_pkg`:
  - Q1.6 width constant `ATTN_DW` = 8.
  - `N_FEAT_DEFAULT` = 4.
  - Enum `qk_tx_state_t` {IDLE, SEND, DONE}, 2 bits, encoded 00/01/10.
- One sub-module, `qk_feature_buf`: 2×N_FEAT register file with a synchronous write port and a combinational read port selected by beat index (`sel` = beat[0], `idx` = beat>>1).
- Top level holds the FSM, beat counter, output registers and the err flag.

## Test plan
- Load Q = {0x40, 0x20, 0xC0, 0x7F} and K = {0x40, 0xE0, 0x40, 0x01}, hold `m_rdy`=1, pulse `start` → beats 40,40,20,E0,C0,40,7F,01 on consecutive cycles, starting the cycle after `start`.
  - `m_last` high only on 01.
  - `done` pulses one cycle after the 01 handshake.
- Same load, random `m_rdy` at 50% → identical 8-beat sequence.
  - `m_data` stable during every stall.
  - Exactly 8 handshakes; `busy` high throughout the stream.
- During SEND: pulse `start` and write Q[0]=0x11 → stream unchanged and `err`=1.
  - After DONE, next transfer still sends the original Q[0]=0x40.
- Assert `rst_n`=0 after 3 handshakes → next cycle `m_vld`=0, `busy`=0, buffer reads 0.
  - A new `start` with no reload sends eight 0x00 beats.
- Write Q[1]=0x55 in the same cycle as `start` → beat 2 is 0x55.
- Connect to `tt_um_attention_top`, stream Q[0]=0x40, K[0]=0x40 → engine `rdy` drops after beat 0, engine enters its accumulate state, and no protocol violation is flagged by the handshake checker.
